// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory-side responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    IO_DONE
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          MAX_WAIT        = 15;

endpackage

// File: rtl/mem_io_port.sv
// Memory-mapped board I/O: switch synchroniser and hex-display register.
module mem_io_port (
  input  logic        Clk,
  input  logic        reset,
  input  logic        ld_hex,
  input  logic [15:0] din,
  input  logic [15:0] sw,
  output logic [15:0] sw_sync,
  output logic [15:0] hex_out
);

  logic [15:0] sw_meta;

  // Two flops so the FSM never samples a switch mid-transition.
  always_ff @(posedge Clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset)
      hex_out <= '0;
    else if (ld_hex)
      hex_out <= din;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory responder: timed async-SRAM cycles plus one memory-mapped I/O
// address, returning a one-cycle ready pulse to the control FSM.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  input  logic [15:0] sw,
  output logic [15:0] hex_out
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("mem_access_ctrl: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  mem_state_t  state, next_state;
  logic [3:0]  cnt;
  logic        rw_q;
  logic        accept;
  logic        is_io;
  logic        cnt_last;
  logic        ld_hex;
  logic [15:0] sw_sync;

  assign accept   = (state == IDLE) && req;
  assign is_io    = (addr == IO_ADDR);
  assign cnt_last = (cnt == CNT_LAST);
  // Hex register loads on the accepting edge so it is valid while ready is high.
  assign ld_hex   = accept && is_io && rw;

  mem_io_port u_io (
    .Clk     (Clk),
    .reset   (reset),
    .ld_hex  (ld_hex),
    .din     (wdata),
    .sw      (sw),
    .sw_sync (sw_sync),
    .hex_out (hex_out)
  );

  always_ff @(posedge Clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = is_io ? IO_DONE : ACCESS;
      ACCESS:  if (cnt_last) next_state = DONE;
      DONE:    next_state = IDLE;
      IO_DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured only at accept, so mid-access changes are ignored.
  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt         <= '0;
      rw_q        <= 1'b0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      if (accept) begin
        rw_q <= rw;
        cnt  <= '0;
        if (!is_io) begin
          sram_addr <= addr;
          if (rw)
            sram_dq_out <= wdata;
        end else if (!rw) begin
          rdata <= sw_sync;
        end
      end
      if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
        if (cnt_last && !rw_q)
          rdata <= sram_dq_in;
      end
    end
  end

  // Strobes come straight from the state register, never from request inputs.
  always_comb begin
    ready      = 1'b0;
    busy       = 1'b1;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      ACCESS: begin
        sram_ce_n = 1'b0;
        if (rw_q) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE:    ready = 1'b1;
      IO_DONE: ready = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural async-SRAM model;
// a second instance covers the WAIT_CYCLES=1 build.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        reset;
  logic        req0, req1, rw;
  logic [15:0] addr, wdata, sw;

  logic [15:0] rdata0, sram_addr0, sram_dq_out0, sram_dq_in0, hex_out0;
  logic        ready0, busy0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_dq_oe0;
  logic [15:0] rdata1, sram_addr1, sram_dq_out1, sram_dq_in1, hex_out1;
  logic        ready1, busy1, sram_ce_n1, sram_oe_n1, sram_we_n1, sram_dq_oe1;

  logic [15:0] mem [0:65535];
  bit          use1;
  int          total = 0;
  int          bad   = 0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.WAIT_CYCLES(2)) dut0 (
    .Clk(Clk), .reset(reset), .req(req0), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .busy(busy0),
    .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
    .sram_dq_in(sram_dq_in0), .sw(sw), .hex_out(hex_out0)
  );

  mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .reset(reset), .req(req1), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ready(ready1), .busy(busy1),
    .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
    .sram_dq_in(sram_dq_in1), .sw(sw), .hex_out(hex_out1)
  );

  // Async SRAM: reads are combinational under CE/OE, writes land while WE is low.
  assign sram_dq_in0 = (!sram_ce_n0 && !sram_oe_n0) ? mem[sram_addr0] : 16'h0000;
  assign sram_dq_in1 = (!sram_ce_n1 && !sram_oe_n1) ? mem[sram_addr1] : 16'h0000;

  always @(posedge Clk) begin
    if (!sram_ce_n0 && !sram_we_n0 && sram_dq_oe0)
      mem[sram_addr0] <= sram_dq_out0;
  end

  wire        ready_s = use1 ? ready1     : ready0;
  wire        ce_s    = use1 ? sram_ce_n1 : sram_ce_n0;
  wire        oe_s    = use1 ? sram_oe_n1 : sram_oe_n0;
  wire        we_s    = use1 ? sram_we_n1 : sram_we_n0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issues one access and returns at the negedge where ready is seen.
  task automatic applyStimulus(input bit sel, input logic rw_i, input logic [15:0] a,
                               input logic [15:0] d, output int lat, output int oe_lo,
                               output int we_lo, output int ce_lo, output bit dq_ok);
    @(negedge Clk);
    use1  = sel;
    rw    = rw_i;
    addr  = a;
    wdata = d;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    lat = 0; oe_lo = 0; we_lo = 0; ce_lo = 0; dq_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (!ce_s) ce_lo++;
      if (!oe_s) oe_lo++;
      if (!we_s) begin
        we_lo++;
        if (sram_dq_out0 !== d || sram_dq_oe0 !== 1'b1) dq_ok = 1'b0;
      end
      if (ready_s) begin
        lat = i;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int lat, oe_lo, we_lo, ce_lo, rdy, gap, extra;
    bit dq_ok;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rw = 1'b0; use1 = 1'b0;
    addr = '0; wdata = '0; sw = '0;
    mem[16'h3000] = 16'hBEEF;
    mem[16'h0042] = 16'h0000;
    mem[16'h0001] = 16'h7777;

    repeat (3) @(negedge Clk);
    checkOutput("reset_ctl", {ready0, busy0, sram_dq_oe0}, 3'b000);
    checkOutput("reset_strobes", {sram_ce_n0, sram_oe_n0, sram_we_n0}, 3'b111);
    checkOutput("reset_rdata", rdata0, 16'h0000);
    checkOutput("reset_pins", {sram_addr0, sram_dq_out0}, 32'h0);
    checkOutput("reset_hex", hex_out0, 16'h0000);
    reset = 1'b0;

    $display("[TB] SRAM read 0x3000");
    applyStimulus(0, 1'b0, 16'h3000, 16'h0000, lat, oe_lo, we_lo, ce_lo, dq_ok);
    checkOutput("rd_latency", lat, 3);
    checkOutput("rd_rdata", rdata0, 16'hBEEF);
    checkOutput("rd_oe_cycles", oe_lo, 2);
    checkOutput("rd_we_cycles", we_lo, 0);

    $display("[TB] SRAM write 0x0042");
    applyStimulus(0, 1'b1, 16'h0042, 16'h1234, lat, oe_lo, we_lo, ce_lo, dq_ok);
    checkOutput("wr_latency", lat, 3);
    checkOutput("wr_we_cycles", we_lo, 2);
    checkOutput("wr_oe_cycles", oe_lo, 0);
    checkOutput("wr_dq_stable", dq_ok, 1'b1);
    checkOutput("wr_mem", mem[16'h0042], 16'h1234);
    checkOutput("wr_rdata_kept", rdata0, 16'hBEEF);

    $display("[TB] I/O write then read");
    applyStimulus(0, 1'b1, 16'hFFFF, 16'h00A5, lat, oe_lo, we_lo, ce_lo, dq_ok);
    checkOutput("io_wr_latency", lat, 1);
    checkOutput("io_hex", hex_out0, 16'h00A5);
    checkOutput("io_wr_no_strobe", ce_lo + oe_lo + we_lo, 0);
    @(negedge Clk);
    sw = 16'h5A5A;
    repeat (2) @(negedge Clk);
    applyStimulus(0, 1'b0, 16'hFFFF, 16'h0000, lat, oe_lo, we_lo, ce_lo, dq_ok);
    checkOutput("io_rd_latency", lat, 1);
    checkOutput("io_rd_rdata", rdata0, 16'h5A5A);
    checkOutput("io_rd_no_strobe", ce_lo + oe_lo + we_lo, 0);
    checkOutput("io_hex_kept", hex_out0, 16'h00A5);

    $display("[TB] back-to-back");
    @(negedge Clk);
    use1 = 1'b0; rw = 1'b0; addr = 16'h3000; req0 = 1'b1;
    rdy = 0; gap = 0; extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (ready0) rdy++;
      else if (rdy == 1 && !busy0) gap++;
      if (rdy >= 2) begin
        req0 = 1'b0;
        extra++;
        if (extra > 6) break;
      end
    end
    req0 = 1'b0;
    checkOutput("b2b_accesses", rdy, 2);
    checkOutput("b2b_idle_gap", gap, 1);
    checkOutput("b2b_rdata", rdata0, 16'hBEEF);

    $display("[TB] reset mid-access");
    @(negedge Clk);
    rw = 1'b0; addr = 16'h3000; req0 = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("rst_in_access", {busy0, sram_oe_n0}, 2'b10);
    reset = 1'b1;
    req0  = 1'b0;
    @(negedge Clk);
    checkOutput("rst_idle", {busy0, ready0}, 2'b00);
    checkOutput("rst_strobes", {sram_ce_n0, sram_oe_n0, sram_we_n0}, 3'b111);
    checkOutput("rst_hex", hex_out0, 16'h0000);
    checkOutput("rst_rdata", rdata0, 16'h0000);
    reset = 1'b0;
    rdy = 0;
    repeat (4) begin
      @(negedge Clk);
      if (ready0) rdy++;
    end
    checkOutput("rst_no_ready", rdy, 0);

    $display("[TB] WAIT_CYCLES=1 read");
    applyStimulus(1, 1'b0, 16'h0001, 16'h0000, lat, oe_lo, we_lo, ce_lo, dq_ok);
    checkOutput("w1_latency", lat, 2);
    checkOutput("w1_rdata", rdata1, 16'h7777);
    checkOutput("w1_oe_cycles", oe_lo, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
